// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: size codes,
// FSM state encoding and the alignment rule.
package dm_access_ctrl_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W_DEF = 10;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_MRG_WR = 3'd2,
        ST_WR     = 3'd3,
        ST_DONE   = 3'd4
    } dm_state_e;

    // Size code 2'b11 behaves as a word access.
    function automatic logic size_is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        if (size[1]) begin
            return lane != 2'b00;
        end else if (size == SIZE_H) begin
            return lane[0];
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request bus from the MEM stage plus the word-wide data-memory port.
// master: MEM stage, slave: access controller, mem: the data memory.
interface dm_access_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic              dm_wr;
    logic [31:0]       dm_dout;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, we, size, sext, addr, wdata,
        output busy, done, err, rdata,
        output dm_addr, dm_din, dm_wr,
        input  dm_dout
    );

    modport mem (
        input  dm_addr, dm_din, dm_wr,
        output dm_dout
    );

endinterface

// File: rtl/dm_lane_mux.sv
// Combinational lane steering: merges a byte/half into an existing word for
// read-modify-write stores, and extracts/extends a byte/half for loads.
// Lanes are little-endian.
module dm_lane_mux
    import dm_access_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              sext,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] extracted
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store merge: replace only the addressed lane of the old word.
    always_comb begin
        merged = old_word;
        if (size_is_word(size)) begin
            merged = wdata;
        end else if (size == SIZE_H) begin
            merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end else begin
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
        end
    end

    // Load extract: pick the addressed lane and sign/zero-extend it.
    always_comb begin
        byte_sel  = old_word[{lane, 3'b000} +: 8];
        half_sel  = old_word[{lane[1], 4'b0000} +: 16];
        extracted = old_word;
        if (!size_is_word(size)) begin
            if (size == SIZE_H) begin
                extracted = {{16{sext & half_sel[15]}}, half_sel};
            end else begin
                extracted = {{24{sext & byte_sel[7]}}, byte_sel};
            end
        end
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Processor-side load/store unit for the word-wide data memory.
// Sub-word stores are read-modify-write; loads are extended per sext.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for req; request fields latched on accept
//   ST_RD     | dm_addr driven, memory read data captured at next edge
//   ST_MRG_WR | merged word on dm_din, dm_wr high for one cycle
//   ST_WR     | word store data on dm_din, dm_wr high for one cycle
//   ST_DONE   | done pulse, err valid; req ignored
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    dm_access_ctrl_if.slave bus
);

    dm_state_e         state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [31:0]       dm_din_q, dm_din_d;

    logic [31:0]       merged_word;
    logic [31:0]       load_word;
    logic [31-ADDR_W-2:0] unused_addr_hi;

    assign unused_addr_hi = bus.addr[31:ADDR_W+2];

    dm_lane_mux u_lane_mux (
        .old_word  (bus.dm_dout),
        .wdata     (wdata_q),
        .size      (size_q),
        .lane      (lane_q),
        .sext      (sext_q),
        .merged    (merged_word),
        .extracted (load_word)
    );

    // State and datapath registers; async clear kills any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            size_q    <= SIZE_B;
            sext_q    <= 1'b0;
            lane_q    <= 2'b00;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            dm_addr_q <= '0;
            dm_din_q  <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            sext_q    <= sext_d;
            lane_q    <= lane_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            dm_addr_q <= dm_addr_d;
            dm_din_q  <= dm_din_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        sext_d    = sext_q;
        lane_d    = lane_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        dm_addr_d = dm_addr_q;
        dm_din_d  = dm_din_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    we_d      = bus.we;
                    size_d    = bus.size;
                    sext_d    = bus.sext;
                    lane_d    = bus.addr[1:0];
                    wdata_d   = bus.wdata;
                    dm_addr_d = bus.addr[ADDR_W+1:2];
                    err_d     = misaligned(bus.size, bus.addr[1:0]);
                    if (misaligned(bus.size, bus.addr[1:0])) begin
                        state_d = ST_DONE;
                    end else if (bus.we && size_is_word(bus.size)) begin
                        dm_din_d = bus.wdata;
                        state_d  = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (we_q) begin
                    dm_din_d = merged_word;
                    state_d  = ST_MRG_WR;
                end else begin
                    rdata_d = load_word;
                    state_d = ST_DONE;
                end
            end
            ST_MRG_WR, ST_WR: state_d = ST_DONE;
            ST_DONE:          state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.busy    = state_q != ST_IDLE;
        bus.done    = state_q == ST_DONE;
        bus.err     = (state_q == ST_DONE) && err_q;
        bus.dm_wr   = (state_q == ST_WR) || (state_q == ST_MRG_WR);
        bus.rdata   = rdata_q;
        bus.dm_addr = dm_addr_q;
        bus.dm_din  = dm_din_q;
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: negedge-write memory, request-level reference
// model checked every cycle, and directed requests with literal expectations.
module tb_dm_access_ctrl;

    localparam int AW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_access_ctrl_if #(.ADDR_W(AW)) bus ();

    dm_access_ctrl #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] dmem    [0:1023] = '{default: '0};
    logic [31:0] ref_mem [0:1023] = '{default: '0};

    assign bus.dm_dout = dmem[bus.dm_addr];

    always @(negedge clk) begin
        if (bus.dm_wr) dmem[bus.dm_addr] = bus.dm_din;
    end

    int n_chk  = 0;
    int n_err  = 0;
    int e_cnt  = 0;
    int tot_wr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Request-level model: one outstanding request, latency from the access type.
    bit          active;
    bit          m_we, m_mis, exp_done, exp_wr;
    int          m_done, m_free, m_wr_cnt, sh;
    logic [9:0]  m_idx, m_addr_hold;
    logic [31:0] m_hold, m_newword, m_rd, old, v, mask;
    logic [1:0]  lane;
    bit          word;

    initial begin : model_cmp
        active = 0; m_free = 0; m_hold = '0; m_addr_hold = '0; m_wr_cnt = 0;
        forever begin
            @(posedge clk);
            e_cnt++;
            if (rst_n) begin
                if (active && e_cnt == m_done && !m_mis) begin
                    if (m_we) ref_mem[m_idx] = m_newword;
                    else      m_hold = m_rd;
                end
                if (bus.req && e_cnt >= m_free) begin
                    m_idx  = bus.addr[11:2];
                    lane   = bus.addr[1:0];
                    word   = (bus.size >= 2'd2);
                    m_mis  = (word && lane != 2'd0) || (bus.size == 2'd1 && lane[0]);
                    m_we   = bus.we;
                    m_done = e_cnt + (m_mis ? 0 : ((!bus.we || word) ? 1 : 2));
                    m_free = m_done + 2;
                    m_addr_hold = m_idx;
                    m_wr_cnt = 0;
                    active = 1;
                    old = ref_mem[m_idx];
                    if (word) begin
                        m_newword = bus.wdata;
                        m_rd      = old;
                    end else if (bus.size == 2'd0) begin
                        sh   = 8 * lane;
                        mask = 32'hFF << sh;
                        m_newword = (old & ~mask) | ((bus.wdata & 32'hFF) << sh);
                        v = (old >> sh) & 32'hFF;
                        if (bus.sext && v[7]) v = v | 32'hFFFFFF00;
                        m_rd = v;
                    end else begin
                        sh   = lane[1] ? 16 : 0;
                        mask = 32'hFFFF << sh;
                        m_newword = (old & ~mask) | ((bus.wdata & 32'hFFFF) << sh);
                        v = (old >> sh) & 32'hFFFF;
                        if (bus.sext && v[15]) v = v | 32'hFFFF0000;
                        m_rd = v;
                    end
                end
            end
            @(negedge clk);
            if (!rst_n) begin
                chk("rst busy", {31'd0, bus.busy}, 0);
                chk("rst done", {31'd0, bus.done}, 0);
                chk("rst err", {31'd0, bus.err}, 0);
                chk("rst dm_wr", {31'd0, bus.dm_wr}, 0);
                chk("rst rdata", bus.rdata, 0);
                chk("rst dm_addr", {22'd0, bus.dm_addr}, 0);
                chk("rst dm_din", bus.dm_din, 0);
                active = 0; m_free = 0; m_hold = '0; m_addr_hold = '0;
            end else begin
                exp_done = active && e_cnt == m_done;
                exp_wr   = active && m_we && !m_mis && e_cnt == m_done - 1;
                chk("busy", {31'd0, bus.busy}, {31'd0, active});
                chk("done", {31'd0, bus.done}, {31'd0, exp_done});
                chk("err", {31'd0, bus.err}, {31'd0, exp_done && m_mis});
                chk("dm_wr", {31'd0, bus.dm_wr}, {31'd0, exp_wr});
                chk("rdata", bus.rdata, m_hold);
                chk("dm_addr", {22'd0, bus.dm_addr}, {22'd0, m_addr_hold});
                if (bus.dm_wr) begin
                    tot_wr++;
                    m_wr_cnt++;
                    if (exp_wr) chk("dm_din", bus.dm_din, m_newword);
                end
                if (exp_done) begin
                    chk("wr pulses per req", m_wr_cnt, (m_we && !m_mis) ? 1 : 0);
                    chk("mem word", dmem[m_idx], ref_mem[m_idx]);
                    active = 0;
                end
            end
        end
    end

    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                          input logic exp_err, input int exp_pulses,
                          input bit chk_rd, input logic [31:0] exp_rd);
        int acc;
        int w0;
        bit seen;
        seen = 0;
        @(posedge clk); #1;
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sext = sx; bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        bus.req = 1'b0;
        acc = e_cnt;
        w0  = tot_wr;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                chk({tag, " latency"}, e_cnt - acc, exp_lat);
                chk({tag, " err"}, {31'd0, bus.err}, {31'd0, exp_err});
                if (chk_rd) chk({tag, " rdata"}, bus.rdata, exp_rd);
            end
        end
        if (!seen) chk({tag, " done timeout"}, 0, 1);
        chk({tag, " dm_wr pulses"}, tot_wr - w0, exp_pulses);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w0;
        bus.req = 0; bus.we = 0; bus.size = 2'd0; bus.sext = 0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_req("sw", 1, 2'd2, 0, 32'h010, 32'hDEADBEEF, 1, 0, 1, 0, '0);
        do_req("lw", 0, 2'd2, 1, 32'h010, 32'h0, 1, 0, 0, 1, 32'hDEADBEEF);
        do_req("sw2", 1, 2'd2, 0, 32'h010, 32'h11223344, 1, 0, 1, 0, '0);
        do_req("sb", 1, 2'd0, 0, 32'h013, 32'h000000A5, 2, 0, 1, 0, '0);
        chk("sb mem[4]", dmem[4], 32'hA5223344);
        do_req("lb", 0, 2'd0, 1, 32'h013, 32'h0, 1, 0, 0, 1, 32'hFFFFFFA5);
        do_req("lbu", 0, 2'd0, 0, 32'h013, 32'h0, 1, 0, 0, 1, 32'h000000A5);
        do_req("lbu lane1", 0, 2'd0, 0, 32'h011, 32'h0, 1, 0, 0, 1, 32'h00000033);
        do_req("sh", 1, 2'd1, 0, 32'h022, 32'h00008001, 2, 0, 1, 0, '0);
        chk("sh mem[8]", dmem[8], 32'h80010000);
        do_req("lh", 0, 2'd1, 1, 32'h022, 32'h0, 1, 0, 0, 1, 32'hFFFF8001);
        do_req("lhu", 0, 2'd1, 0, 32'h022, 32'h0, 1, 0, 0, 1, 32'h00008001);
        do_req("lw size3", 0, 2'd3, 1, 32'h020, 32'h0, 1, 0, 0, 1, 32'h80010000);

        do_req("mis lw", 0, 2'd2, 0, 32'h002, 32'h0, 0, 1, 0, 1, 32'h80010000);
        chk("mis lw mem[0]", dmem[0], 32'h0);
        do_req("mis sh", 1, 2'd1, 0, 32'h005, 32'h0000FFFF, 0, 1, 0, 0, '0);
        chk("mis sh mem[1]", dmem[1], 32'h0);

        // Reset while the merged word is on the bus, before the write negedge.
        @(posedge clk); #1;
        w0 = tot_wr;
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.sext = 0;
        bus.addr = 32'h010; bus.wdata = 32'h0000005A;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        chk("pre-rst dm_wr", {31'd0, bus.dm_wr}, 1);
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst mem[4] kept", dmem[4], 32'hA5223344);
        chk("rst no write", tot_wr - w0, 0);
        do_req("lw after rst", 0, 2'd2, 0, 32'h010, 32'h0, 1, 0, 0, 1, 32'hA5223344);

        // req held high for 10 cycles of word stores.
        @(posedge clk); #1;
        w0 = tot_wr;
        for (int i = 0; i < 10; i++) begin
            bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.sext = 0;
            bus.addr = 32'h100 + 4 * i; bus.wdata = 32'hC0000000 + i;
            @(posedge clk); #1;
        end
        bus.req = 1'b0;
        for (int i = 0; i < 10 && bus.busy; i++) @(negedge clk);
        chk("b2b idle", {31'd0, bus.busy}, 0);
        chk("b2b writes", tot_wr - w0, 4);
        chk("b2b mem[64]", dmem[64], 32'hC0000000);
        chk("b2b mem[65]", dmem[65], 32'h0);
        chk("b2b mem[67]", dmem[67], 32'hC0000003);
        chk("b2b mem[70]", dmem[70], 32'hC0000006);
        chk("b2b mem[73]", dmem[73], 32'hC0000009);
        chk("b2b mem[74]", dmem[74], 32'h0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
